uart_tx_sched: RTL

Round-robin scheduler that shares one UART TX parallel-to-serial shifter between `N_REQ` byte producers. It arbitrates requests, loads the winning byte into the shifter, and frames the serial stream with a start bit, an optional parity bit and stop bit(s) onto the `tx` line. It sits between the producer FIFOs and the pad; the shifter is the block's only datapath resource.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART TX scheduler
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int   DATA_BITS       = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick: first requester at or after ptr, one-hot plus index
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any
);

  localparam int IDW = $clog2(N_REQ);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - shares one UART TX shifter among N_REQ producers; even parity bit under UART_TX_PARITY_EN
module uart_tx_sched
  import uart_tx_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*8-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     piso_en,
  output logic [7:0]               piso_data,
  input  logic                     piso_serial,
  input  logic                     piso_finish,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     err
);

  localparam int IDW = $clog2(N_REQ);

  state_t           state, state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       hold;
  logic [IDW-1:0]   rr_ptr;
  logic [N_REQ-1:0] arb_onehot;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;
  logic [7:0]       arb_byte;
  logic             data_last;
  logic             stop_last;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_onehot),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign data_last = (bit_cnt == 3'(DATA_BITS - 1));
  assign stop_last = (bit_cnt == 3'(STOP_BITS - 1));
  assign busy      = (state != ST_IDLE);

  always_comb begin
    arb_byte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (arb_onehot[i]) arb_byte = req_data[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    piso_en   = 1'b0;
    piso_data = '0;
    tx        = UART_IDLE_LEVEL;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready = arb_onehot;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        piso_en   = 1'b1;
        piso_data = hold;
        state_nxt = ST_START;
      end
      ST_START: begin
        tx        = 1'b0;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = piso_serial;
`ifdef UART_TX_PARITY_EN
        if (data_last) state_nxt = ST_PARITY;
`else
        if (data_last) state_nxt = ST_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx        = ^hold;
        state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (stop_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // bit_cnt counts data bits in DATA and stop bits in STOP, idle at zero elsewhere
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      hold     <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ST_IDLE && arb_any) begin
        hold     <= arb_byte;
        grant_id <= arb_idx;
        rr_ptr   <= (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (state == ST_DATA)      bit_cnt <= data_last ? '0 : bit_cnt + 3'd1;
      else if (state == ST_STOP) bit_cnt <= stop_last ? '0 : bit_cnt + 3'd1;
      else                       bit_cnt <= '0;
      if (state == ST_DATA && data_last && !piso_finish) err <= 1'b1;
    end
  end

endmodule
